input_pin: RTL and testbench

Memory-mapped input-pin peripheral for the processor's input bus; it is the read-side counterpart of the output-pin peripheral on the output bus. It synchronises and debounces a PIN_WIDTH-bit external input and records per-bit change events in sticky flags. Both values are returned on bus reads at two consecutive addresses, and an interrupt is raised while any flag is set. Reading the flag register clears the flags.

---
 rtl/input_pin.sv | 118 +++++++++++
 tb/tb_input_pin.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_pin.sv
// input_pin: memory-mapped input-pin peripheral.
// Each pin is synchronised and debounced. A pin changing level sets a
// sticky per-bit flag. The level register sits at DEVADDR and the flag
// register at DEVADDR+1 (8-bit wrap). Reading the flag register clears
// the flags. IRQ stays high while any flag is set.

// Per-pin lane: two-flop synchroniser followed by a debounce counter.
module input_pin_bit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic stable,
  output logic evt
);
  // Width is at least one bit so that DEBOUNCE_CYCLES=1 still builds.
  // In that case the counter is never used above zero.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          sync;
  logic [CW-1:0] cnt;

  // evt marks the edge on which the stable level flips.
  assign evt = (sync != stable) && (cnt == CNT_MAX);

  // Synchronise the pin. Move stable only after DEBOUNCE_CYCLES differing samples in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1   <= pin;
      sync <= s1;
      if (sync == stable) begin
        cnt <= '0;
      end else if (evt) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module input_pin #(
  parameter int         PIN_WIDTH       = 1,
  parameter logic [7:0] DEVADDR         = 8'h00,
  parameter int         DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           INBUS_ADDR,
  input  logic                 INBUS_RE,
  output logic [PIN_WIDTH-1:0] INBUS_DATA,
  output logic                 INBUS_VALID,
  input  logic [PIN_WIDTH-1:0] INPUT_PIN,
  output logic                 IRQ
);
  // The flag register sits at the next address. The add wraps at 8 bits.
  localparam logic [7:0] FLAGADDR = DEVADDR + 8'd1;

  logic [PIN_WIDTH-1:0] stable;
  logic [PIN_WIDTH-1:0] evt;
  logic [PIN_WIDTH-1:0] flags;
  logic [PIN_WIDTH-1:0] clr;
  logic                 lvl_hit;
  logic                 flg_hit;

  genvar gi;
  generate
    for (gi = 0; gi < PIN_WIDTH; gi++) begin : g_lane
      input_pin_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
        .clk    (clk),
        .reset  (reset),
        .pin    (INPUT_PIN[gi]),
        .stable (stable[gi]),
        .evt    (evt[gi])
      );
    end
  endgenerate

  assign lvl_hit = INBUS_RE && (INBUS_ADDR == DEVADDR);
  assign flg_hit = INBUS_RE && (INBUS_ADDR == FLAGADDR);
  assign IRQ     = |flags;

  // A flag read clears only the bits it returned. An event on the same edge survives.
  always_comb begin
    clr = '0;
    if (flg_hit) clr = flags;
  end

  // Sticky flags and the registered read response. Zero data when idle allows OR-combining.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags       <= '0;
      INBUS_DATA  <= '0;
      INBUS_VALID <= 1'b0;
    end else begin
      flags <= (flags & ~clr) | evt;
      if (lvl_hit) begin
        INBUS_DATA  <= stable;
        INBUS_VALID <= 1'b1;
      end else if (flg_hit) begin
        INBUS_DATA  <= flags;
        INBUS_VALID <= 1'b1;
      end else begin
        INBUS_DATA  <= '0;
        INBUS_VALID <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_input_pin.sv
// tb_input_pin: scoreboard bench for input_pin.
// Two instances share the pins and the bus. One sits at 8'h10 and the
// other at 8'hFF, so the flag address of the second wraps to 8'h00.
module tb_input_pin;
  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   addr = 8'h00;
  logic         re = 1'b0;
  logic [W-1:0] pins = '0;
  logic [W-1:0] data_a, data_b;
  logic         valid_a, valid_b, irq_a, irq_b;

  input_pin #(.PIN_WIDTH(W), .DEVADDR(8'h10), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .INBUS_ADDR(addr), .INBUS_RE(re),
    .INBUS_DATA(data_a), .INBUS_VALID(valid_a), .INPUT_PIN(pins), .IRQ(irq_a));

  input_pin #(.PIN_WIDTH(W), .DEVADDR(8'hFF), .DEBOUNCE_CYCLES(D)) dut_w (
    .clk(clk), .reset(reset), .INBUS_ADDR(addr), .INBUS_RE(re),
    .INBUS_DATA(data_b), .INBUS_VALID(valid_b), .INPUT_PIN(pins), .IRQ(irq_b));

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [W-1:0] data;
  } exp_t;

  exp_t         qa[$];
  exp_t         qb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;

  // Reference model. Pin samples are kept per edge. A bit's level flips
  // once the last D synchronised samples all disagree with it. The
  // synchronised value before edge n is the pin sampled at edge n-2.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_stable, m_flags_a, m_flags_b, m_evt;
  logic         alld;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_stable  = '0;
      m_flags_a = '0;
      m_flags_b = '0;
      hist.delete();
      for (int i = 0; i <= D; i++) hist.push_back('0);
      qa.delete();
      qb.delete();
    end else begin
      cyc++;
      m_evt = '0;
      for (int i = 0; i < W; i++) begin
        alld = 1'b1;
        for (int k = 2; k <= D + 1; k++)
          if (hist[hist.size() - k][i] == m_stable[i]) alld = 1'b0;
        m_evt[i] = alld;
      end
      if (re && addr == 8'h10) qa.push_back('{cyc, m_stable});
      if (re && addr == 8'h11) qa.push_back('{cyc, m_flags_a});
      if (re && addr == 8'hFF) qb.push_back('{cyc, m_stable});
      if (re && addr == 8'h00) qb.push_back('{cyc, m_flags_b});
      m_flags_a = ((re && addr == 8'h11) ? '0 : m_flags_a) | m_evt;
      m_flags_b = ((re && addr == 8'h00) ? '0 : m_flags_b) | m_evt;
      m_stable  = m_stable ^ m_evt;
      hist.push_back(pins);
      if (hist.size() > D + 2) void'(hist.pop_front());
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: on every falling edge, compare the bus response and IRQ of both instances.
  logic due_a, due_b;
  always @(negedge clk) begin
    if (!reset) begin
      chk("irq_a", {31'b0, irq_a}, {31'b0, |m_flags_a});
      chk("irq_b", {31'b0, irq_b}, {31'b0, |m_flags_b});
      due_a = (qa.size() > 0) && (qa[0].cyc <= cyc);
      due_b = (qb.size() > 0) && (qb[0].cyc <= cyc);
      chk("valid_a", {31'b0, valid_a}, {31'b0, due_a});
      chk("valid_b", {31'b0, valid_b}, {31'b0, due_b});
      if (valid_a && due_a) chk("data_a", 32'(data_a), 32'(qa[0].data));
      if (valid_b && due_b) chk("data_b", 32'(data_b), 32'(qb[0].data));
      if (!valid_a) chk("idle_data_a", 32'(data_a), 32'd0);
      if (!valid_b) chk("idle_data_b", 32'(data_b), 32'd0);
      if (due_a) void'(qa.pop_front());
      if (due_b) void'(qb.pop_front());
    end
  end

  // One read strobe. The task is called and returns on a falling edge.
  task automatic rd(input logic [7:0] a);
    re = 1'b1;
    addr = a;
    @(negedge clk);
    re = 1'b0;
  endtask

  int k0;
  int n;
  int hold[W];

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // After reset the level register reads as zero.
    rd(8'h10);

    // Debounce latency. Pins change before edge k and IRQ must rise at edge k+5.
    pins = 4'b0101;
    k0 = cyc + 1;
    n = 0;
    while (!irq_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency_edge", cyc, k0 + 5);
    rd(8'h10);
    rd(8'h11);
    rd(8'h00);

    // A 3-cycle glitch on bit 0 sets no flag.
    pins[0] = 1'b0;
    repeat (3) @(negedge clk);
    pins[0] = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_irq", {31'b0, irq_a}, 32'd0);
    rd(8'h10);

    // A 4-cycle pulse sets flag 0, on both the fall and the return.
    pins[0] = 1'b0;
    repeat (4) @(negedge clk);
    pins[0] = 1'b1;
    repeat (14) @(negedge clk);
    chk("pulse_irq", {31'b0, irq_a}, 32'd1);

    // Race: a flag read lands on the same edge as an event on bit 2.
    pins[2] = 1'b0;
    repeat (5) @(negedge clk);
    rd(8'h11);
    chk("race_irq_kept", {31'b0, irq_a}, 32'd1);
    rd(8'h11);
    chk("race_irq_clr", {31'b0, irq_a}, 32'd0);

    // Address decode: misses, a strobe-less cycle, and the wrapped flag address.
    pins = 4'b1010;
    repeat (8) @(negedge clk);
    rd(8'h12);
    rd(8'h0F);
    addr = 8'h11;
    @(negedge clk);
    chk("no_strobe_irq", {31'b0, irq_a}, 32'd1);
    rd(8'h00);
    rd(8'hFF);

    // Back-to-back reads: level, flags, level.
    re = 1'b1; addr = 8'h10;
    @(negedge clk); addr = 8'h11;
    @(negedge clk); addr = 8'h10;
    @(negedge clk); re = 1'b0;
    chk("b2b_irq", {31'b0, irq_a}, 32'd0);

    // Random pins with mixed hold lengths, plus random reads.
    for (int i = 0; i < W; i++) hold[i] = $urandom_range(1, 7);
    repeat (600) begin
      for (int i = 0; i < W; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          pins[i] = ~pins[i];
          hold[i] = $urandom_range(1, 8);
        end
      end
      re = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0: addr = 8'h10;
        1: addr = 8'h11;
        2: addr = 8'h12;
        3: addr = 8'h0F;
        4: addr = 8'hFF;
        5: addr = 8'h00;
        default: addr = 8'($urandom_range(0, 255));
      endcase
      @(negedge clk);
    end
    re = 1'b0;

    // Assert reset mid-cycle while a response is on the bus. All outputs clear at once.
    pins = 4'b1111;
    repeat (10) @(negedge clk);
    re = 1'b1; addr = 8'h10;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_data", 32'(data_a), 32'd0);
    chk("rst_valid", {31'b0, valid_a}, 32'd0);
    chk("rst_irq", {31'b0, irq_a}, 32'd0);
    chk("rst_irq_b", {31'b0, irq_b}, 32'd0);
    @(negedge clk);
    re = 1'b0;
    pins = '0;
    reset = 1'b0;
    rd(8'h10);
    rd(8'h11);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
